// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a carry flop, LSB-first, one bit per clock.
// Optional subtract support is built when SERIAL_ADDER_SUB_EN is defined.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             mode,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] b_load;
    logic             c_load;
    logic             s_bit;
    logic             c_next;

`ifdef SERIAL_ADDER_SUB_EN
    // Subtract as a + ~b + 1; cin is not used in that mode.
    assign b_load = mode ? ~b : b;
    assign c_load = mode ? 1'b1 : cin;
`else
    logic unused_mode;
    assign unused_mode = mode;
    assign b_load      = b;
    assign c_load      = cin;
`endif

    assign s_bit  = sa_q[0] ^ sb_q[0] ^ carry_q;
    assign c_next = (sa_q[0] & sb_q[0]) | (sa_q[0] & carry_q) | (sb_q[0] & carry_q);

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    sa_d    = a;
                    sb_d    = b_load;
                    carry_d = c_load;
                    cnt_d   = '0;
                end
            end
            StRun: begin
                res_d   = {s_bit, res_q[WIDTH-1:1]};
                sa_d    = sa_q >> 1;
                sb_d    = sb_q >> 1;
                carry_d = c_next;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = StDone;
                    sum_d   = {s_bit, res_q[WIDTH-1:1]};
                    cout_d  = c_next;
                    // Carry into the MSB is the carry held while the MSB is processed.
                    ovf_d   = carry_q ^ c_next;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            sa_q    <= '0;
            sb_q    <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign busy = (state_q != StIdle);
    assign done = (state_q == StDone);

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8).
// Subtract expectations follow SERIAL_ADDER_SUB_EN as seen by this compile.
module tb_serial_adder;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       mode;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    logic       busy;
    logic       done;

    int checks;
    int failures;

    serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .mode  (mode),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf),
        .busy  (busy),
        .done  (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Issues one start pulse and observes 20 cycles after the capture edge; no checking here.
    task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                          input logic im, output logic [7:0] osum, output logic oc,
                          output logic oo, output int lat, output int busy_cycles,
                          output int dones);
        osum = 8'h00; oc = 1'b0; oo = 1'b0;
        lat = -1; busy_cycles = 0; dones = 0;
        a = ia; b = ib; cin = ic; mode = im; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (busy) busy_cycles++;
            if (done) begin
                dones++;
                if (lat < 0) begin
                    lat = i; osum = sum; oc = cout; oo = ovf;
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0; mode = 1'b0;
        #1;
        checks++; if (sum !== 8'h00) begin failures++; $display("FAIL reset_sum got=%h exp=00", sum); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (cout !== 1'b0 || ovf !== 1'b0) begin
            failures++; $display("FAIL reset_flags got=%b%b exp=00", cout, ovf);
        end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL post_reset_idle got=%b%b exp=00", busy, done);
        end
    endtask

    task automatic test_basic_add;
        logic [7:0] s; logic c, o; int lat, bc, nd;
        run_op(8'h5A, 8'h33, 1'b0, 1'b0, s, c, o, lat, bc, nd);
        checks++; if (lat != 8) begin failures++; $display("FAIL basic_latency got=%0d exp=8", lat); end
        checks++; if (s !== 8'h8D) begin failures++; $display("FAIL basic_sum got=%h exp=8d", s); end
        checks++; if (c !== 1'b0) begin failures++; $display("FAIL basic_cout got=%b exp=0", c); end
        checks++; if (o !== 1'b1) begin failures++; $display("FAIL basic_ovf got=%b exp=1", o); end
        checks++; if (bc != 9) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=9", bc); end
        checks++; if (nd != 1) begin failures++; $display("FAIL basic_done_count got=%0d exp=1", nd); end
    endtask

    task automatic test_carry_wrap;
        logic [7:0] s; logic c, o; int lat, bc, nd;
        run_op(8'hFF, 8'h00, 1'b1, 1'b0, s, c, o, lat, bc, nd);
        checks++; if (s !== 8'h00) begin failures++; $display("FAIL wrap1_sum got=%h exp=00", s); end
        checks++; if (c !== 1'b1) begin failures++; $display("FAIL wrap1_cout got=%b exp=1", c); end
        checks++; if (o !== 1'b0) begin failures++; $display("FAIL wrap1_ovf got=%b exp=0", o); end
        run_op(8'h80, 8'h80, 1'b0, 1'b0, s, c, o, lat, bc, nd);
        checks++; if (s !== 8'h00) begin failures++; $display("FAIL wrap2_sum got=%h exp=00", s); end
        checks++; if (c !== 1'b1) begin failures++; $display("FAIL wrap2_cout got=%b exp=1", c); end
        checks++; if (o !== 1'b1) begin failures++; $display("FAIL wrap2_ovf got=%b exp=1", o); end
    endtask

    task automatic test_busy_ignore;
        logic [7:0] s; logic c, o; int lat, bc, nd;
        int hold_err; logic [7:0] res;
        run_op(8'h5A, 8'h33, 1'b0, 1'b0, s, c, o, lat, bc, nd);
        checks++; if (sum !== 8'h8D) begin failures++; $display("FAIL hold_idle_sum got=%h exp=8d", sum); end
        a = 8'h11; b = 8'h22; cin = 1'b0; mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        hold_err = 0; nd = 0; lat = -1; res = 8'h00;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                nd++;
                if (lat < 0) begin lat = i; res = sum; end
            end else if (nd == 0 && sum !== 8'h8D) begin
                hold_err++;
            end
            if (i == 3) begin start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1; end
            if (i == 4) start = 1'b0;
            @(posedge clk); #1;
        end
        checks++; if (hold_err != 0) begin failures++; $display("FAIL hold_during_run got=%0d bad cycles exp=0", hold_err); end
        checks++; if (nd != 1) begin failures++; $display("FAIL ignore_done_count got=%0d exp=1", nd); end
        checks++; if (lat != 8) begin failures++; $display("FAIL ignore_latency got=%0d exp=8", lat); end
        checks++; if (res !== 8'h33) begin failures++; $display("FAIL ignore_sum got=%h exp=33", res); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ignore_idle_after got=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid_run;
        int nd;
        a = 8'hA5; b = 8'h3C; cin = 1'b0; mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1; rst = 1'b1;
        #1;
        checks++; if (sum !== 8'h00) begin failures++; $display("FAIL midreset_sum got=%h exp=00", sum); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL midreset_busy_done got=%b%b exp=00", busy, done);
        end
        checks++; if (cout !== 1'b0 || ovf !== 1'b0) begin
            failures++; $display("FAIL midreset_flags got=%b%b exp=00", cout, ovf);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        nd = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (done || busy) nd++;
        end
        checks++; if (nd != 0) begin failures++; $display("FAIL midreset_no_done got=%0d active cycles exp=0", nd); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp_s [3];
        logic [7:0] got_s [3];
        int dtime [3];
        int nacc, ndone, cyc;
        logic prev_busy;
        exp_s[0] = 8'h03; exp_s[1] = 8'h80; exp_s[2] = 8'h2C;
        for (int k = 0; k < 3; k++) begin got_s[k] = 8'h00; dtime[k] = 0; end
        nacc = 0; ndone = 0; cyc = 0; prev_busy = 1'b0;
        a = 8'h01; b = 8'h02; cin = 1'b0; mode = 1'b0; start = 1'b1;
        for (int i = 0; i < 45; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (busy && !prev_busy) begin
                nacc++;
                if (nacc == 1) begin a = 8'h7F; b = 8'h01; end
                if (nacc == 2) begin a = 8'hC8; b = 8'h64; end
                if (nacc == 3) start = 1'b0;
            end
            prev_busy = busy;
            if (done) begin
                if (ndone < 3) begin dtime[ndone] = cyc; got_s[ndone] = sum; end
                ndone++;
            end
        end
        start = 1'b0;
        checks++; if (ndone != 3) begin failures++; $display("FAIL b2b_done_count got=%0d exp=3", ndone); end
        checks++; if (dtime[1] - dtime[0] != 10) begin
            failures++; $display("FAIL b2b_spacing01 got=%0d exp=10", dtime[1] - dtime[0]);
        end
        checks++; if (dtime[2] - dtime[1] != 10) begin
            failures++; $display("FAIL b2b_spacing12 got=%0d exp=10", dtime[2] - dtime[1]);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (got_s[k] !== exp_s[k]) begin
                failures++; $display("FAIL b2b_sum%0d got=%h exp=%h", k, got_s[k], exp_s[k]);
            end
        end
    endtask

    task automatic test_subtract;
        logic [7:0] s; logic c, o; int lat, bc, nd;
        logic [7:0] e1, e2; logic ec1, ec2;
`ifdef SERIAL_ADDER_SUB_EN
        e1 = 8'hF0; ec1 = 1'b0; e2 = 8'h10; ec2 = 1'b1;
`else
        e1 = 8'h30; ec1 = 1'b0; e2 = 8'h31; ec2 = 1'b0;
`endif
        run_op(8'h10, 8'h20, 1'b0, 1'b1, s, c, o, lat, bc, nd);
        checks++; if (s !== e1) begin failures++; $display("FAIL sub1_sum got=%h exp=%h", s, e1); end
        checks++; if (c !== ec1) begin failures++; $display("FAIL sub1_cout got=%b exp=%b", c, ec1); end
        checks++; if (o !== 1'b0) begin failures++; $display("FAIL sub1_ovf got=%b exp=0", o); end
        run_op(8'h20, 8'h10, 1'b1, 1'b1, s, c, o, lat, bc, nd);
        checks++; if (s !== e2) begin failures++; $display("FAIL sub2_sum got=%h exp=%h", s, e2); end
        checks++; if (c !== ec2) begin failures++; $display("FAIL sub2_cout got=%b exp=%b", c, ec2); end
        checks++; if (o !== 1'b0) begin failures++; $display("FAIL sub2_ovf got=%b exp=0", o); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_basic_add();
        test_carry_wrap();
        test_busy_ignore();
        test_reset_mid_run();
        test_back_to_back();
        test_subtract();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
